// File: rtl/conf_mul_pkg.sv
// conf_mul_pkg: shared sizing and mask helpers for the
// configurable-precision multiplier.
package conf_mul_pkg;

  localparam int CNT_W = 32;
  localparam int MAX_W = 64;

  function automatic int prec_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Keeps the top p bits of a width-bit operand.
  function automatic logic [MAX_W-1:0] prec_mask(
    input int width,
    input int p
  );
    logic [MAX_W-1:0] full;
    full = {MAX_W{1'b1}} >> (MAX_W - width);
    return full & ~(full >> p);
  endfunction

endpackage

// File: rtl/conf_int_mul_trunc.sv
// conf_int_mul_trunc: precision clamp, operand masking and
// approximate-flag generation ahead of the first pipe stage.
module conf_int_mul_trunc
  import conf_mul_pkg::*;
#(
  parameter int DW     = 32,
  parameter int OW     = 32,
  parameter int PREC_W = 6
) (
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  input  logic [PREC_W-1:0] prec,
  input  logic              acc__sel,
  output logic [DW-1:0]     a_m,
  output logic [DW-1:0]     b_m,
  output logic              apx
);

  logic [PREC_W-1:0] p;
  logic [DW-1:0]     m;

  always_comb begin
    p = prec;
    if (prec > PREC_W'(OW)) p = PREC_W'(OW);
    if (acc__sel) p = PREC_W'(DW);
    m = DW'(prec_mask(DW, int'(p)));
  end

  assign a_m = a & m;
  assign b_m = b & m;
  assign apx = p < PREC_W'(DW);

endmodule

// File: rtl/conf_int_mul_pipe.sv
// conf_int_mul_pipe: pipelined configurable-precision multiplier.
// CONF_INT_MUL_PIPE_PERF_CNT_EN adds output handshake counters.
module conf_int_mul_pipe
  import conf_mul_pkg::*;
#(
  parameter  int DATA_PATH_BITWIDTH = 32,
  parameter  int OP_BITWIDTH        = 32,
  parameter  int PIPE_STAGES        = 2,
  localparam int PREC_W = prec_w(DATA_PATH_BITWIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]   a,
  input  logic [DATA_PATH_BITWIDTH-1:0]   b,
  input  logic [PREC_W-1:0]               prec,
  input  logic                            acc__sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DATA_PATH_BITWIDTH-1:0] d,
  output logic                            d_apx_flag
`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                cnt_total,
  output logic [CNT_W-1:0]                cnt_apx
`endif
);

  localparam int W  = DATA_PATH_BITWIDTH;
  localparam int H  = W / 2;
  localparam int PW = 2 * W;
  localparam int LW = W + H;
  localparam int UW = 2 * W - H;

  logic         adv;
  logic         take;
  logic         apx;
  logic [W-1:0] a_m;
  logic [W-1:0] b_m;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  conf_int_mul_trunc #(
    .DW     (W),
    .OW     (OP_BITWIDTH),
    .PREC_W (PREC_W)
  ) u_trunc (
    .a        (a),
    .b        (b),
    .prec     (prec),
    .acc__sel (acc__sel),
    .a_m      (a_m),
    .b_m      (b_m),
    .apx      (apx)
  );

  generate
    if (PIPE_STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid  <= 1'b0;
          d          <= '0;
          d_apx_flag <= 1'b0;
        end else if (adv) begin
          out_valid <= take;
          if (take) begin
            d          <= PW'(a_m) * PW'(b_m);
            d_apx_flag <= apx;
          end
        end
      end
    end else begin : g_multi
      localparam int N = PIPE_STAGES - 1;

      logic          s1_v;
      logic          s1_f;
      logic [LW-1:0] pp_lo;
      logic [UW-1:0] pp_hi;
      logic [PW-1:0] sum;
      logic [N-1:0]  v;
      logic [N-1:0]  f;
      logic [PW-1:0] p_q [N];

      // Stage 1 holds two half-width partial products.
      assign sum = (PW'(pp_hi) << H) + PW'(pp_lo);

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_v  <= 1'b0;
          s1_f  <= 1'b0;
          pp_lo <= '0;
          pp_hi <= '0;
          v     <= '0;
          f     <= '0;
          for (int i = 0; i < N; i++) p_q[i] <= '0;
        end else if (adv) begin
          s1_v <= take;
          if (take) begin
            s1_f  <= apx;
            pp_lo <= LW'(a_m) * LW'(b_m[H-1:0]);
            pp_hi <= UW'(a_m) * UW'(b_m[W-1:H]);
          end
          v[0] <= s1_v;
          if (s1_v) begin
            p_q[0] <= sum;
            f[0]   <= s1_f;
          end
          for (int i = 1; i < N; i++) begin
            v[i] <= v[i-1];
            if (v[i-1]) begin
              p_q[i] <= p_q[i-1];
              f[i]   <= f[i-1];
            end
          end
        end
      end

      assign out_valid  = v[N-1];
      assign d          = p_q[N-1];
      assign d_apx_flag = f[N-1];
    end
  endgenerate

`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_total <= '0;
      cnt_apx   <= '0;
    end else if (out_valid && out_ready) begin
      if (cnt_total != '1)
        cnt_total <= cnt_total + CNT_W'(1);
      if (d_apx_flag && cnt_apx != '1)
        cnt_apx <= cnt_apx + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_conf_int_mul_pipe.sv
// tb_conf_int_mul_pipe: directed and randomized checks of the
// pipelined configurable-precision multiplier.
module tb_conf_int_mul_pipe;

  localparam int DW     = 16;
  localparam int OW     = 16;
  localparam int PS     = 2;
  localparam int PW     = 2 * DW;
  localparam int PREC_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     a;
  logic [DW-1:0]     b;
  logic [PREC_W-1:0] prec;
  logic              acc__sel;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     d;
  logic              d_apx_flag;
`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
  logic [31:0]       cnt_total;
  logic [31:0]       cnt_apx;
`endif

  typedef struct packed {
    logic          f;
    logic [PW-1:0] d;
  } res_t;

  int   total = 0;
  int   bad = 0;
  int   spurious = 0;
  bit   done;
  res_t exp_q[$];
  res_t got_q[$];
  res_t want_q[$];

  conf_int_mul_pipe #(
    .DATA_PATH_BITWIDTH (DW),
    .OP_BITWIDTH        (OW),
    .PIPE_STAGES        (PS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .prec       (prec),
    .acc__sel   (acc__sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .d_apx_flag (d_apx_flag)
`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
    ,
    .cnt_total  (cnt_total),
    .cnt_apx    (cnt_apx)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(
    input logic [DW-1:0]     av,
    input logic [DW-1:0]     bv,
    input logic [PREC_W-1:0] pv,
    input logic              sv
  );
    int              p;
    longint unsigned x;
    longint unsigned y;
    res_t            r;
    p = sv ? DW : ((int'(pv) > OW) ? OW : int'(pv));
    x = 64'(av);
    y = 64'(bv);
    x = (x >> (DW - p)) << (DW - p);
    y = (y >> (DW - p)) << (DW - p);
    r.d = PW'(x * y);
    r.f = (p < DW);
    return r;
  endfunction

  // Scoreboard: beats accepted / products handed off, seen mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          got_q.push_back('{f: d_apx_flag, d: d});
          want_q.push_back(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, prec, acc__sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [DW-1:0]     av,
    input logic [DW-1:0]     bv,
    input logic [PREC_W-1:0] pv,
    input logic              sv
  );
    int n;
    n = 0;
    a = av;
    b = bv;
    prec = pv;
    acc__sel = sv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    if (d !== '0) begin
      bad++;
      $display("FAIL rst_d got=%h want=0", d);
    end
    if (d_apx_flag !== 1'b0) begin
      bad++;
      $display("FAIL rst_flag got=%b want=0", d_apx_flag);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0]     ta [5];
    logic [DW-1:0]     tb [5];
    logic [PREC_W-1:0] tp [5];
    logic              ts [5];
    logic [PW-1:0]     td [5];
    logic              tf [5];
    ta = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tb = '{16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tp = '{5'd3, 5'd8, 5'd0, 5'd16, 5'd31};
    ts = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    td = '{32'h0012_3400, 32'h0012_0000, 32'h0,
           32'hFFFE_0001, 32'hFFFE_0001};
    tf = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tp[i], ts[i]);
      for (int k = 1; k < PS; k++) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL dir%0d_early got=%b want=0", i, out_valid);
        end
        tick();
      end
      total += 3;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_valid got=%b want=1", i, out_valid);
      end
      if (d !== td[i]) begin
        bad++;
        $display("FAIL dir%0d_d got=%h want=%h", i, d, td[i]);
      end
      if (d_apx_flag !== tf[i]) begin
        bad++;
        $display("FAIL dir%0d_flag got=%b want=%b",
                 i, d_apx_flag, tf[i]);
      end
      tick();
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_back_to_back();
    time  t0;
    res_t g;
    res_t w;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++)
      send(DW'($urandom), DW'($urandom),
           PREC_W'($urandom), 1'($urandom));
    total++;
    if ($time - t0 != 80) begin
      bad++;
      $display("FAIL b2b_time got=%0t want=80", $time - t0);
    end
    drain();
    total++;
    if (got_q.size() != 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=8", got_q.size());
    end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      w = want_q.pop_front();
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL b2b_data got=%h want=%h", g, w);
      end
    end
  endtask

  task automatic test_stall();
    res_t          g;
    res_t          w;
    logic [PW-1:0] hold_d;
    logic          hold_f;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(DW'($urandom), DW'($urandom),
               PREC_W'($urandom), 1'($urandom));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        hold_d = d;
        hold_f = d_apx_flag;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
              d !== hold_d || d_apx_flag !== hold_f) begin
            bad++;
            $display("FAIL stall_hold got=%b/%b/%h want=1/0/%h",
                     out_valid, in_ready, d, hold_d);
          end
        end
        tick();
        out_ready = 1'b1;
      end
    join
    drain();
    total++;
    if (got_q.size() != 4) begin
      bad++;
      $display("FAIL stall_count got=%0d want=4", got_q.size());
    end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      w = want_q.pop_front();
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL stall_data got=%h want=%h", g, w);
      end
    end
  endtask

  task automatic test_random();
    res_t g;
    res_t w;
    int   sp0;
    sp0 = spurious;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(DW'($urandom), DW'($urandom),
               PREC_W'($urandom), ($urandom % 4) == 0);
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom % 3) != 0;
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain();
    total++;
    if (got_q.size() != 60) begin
      bad++;
      $display("FAIL rand_count got=%0d want=60", got_q.size());
    end
    while (got_q.size() != 0) begin
      g = got_q.pop_front();
      w = want_q.pop_front();
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL rand_data got=%h want=%h", g, w);
      end
    end
    total++;
    if (spurious != sp0) begin
      bad++;
      $display("FAIL rand_spurious got=%0d want=%0d", spurious, sp0);
    end
  endtask

  task automatic test_reset_midflight();
    int sp0;
    sp0 = spurious;
    out_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF, 5'd0, 1'b1);
    send(16'h1234, 16'h5678, 5'd0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 3;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_valid got=%b want=0", out_valid);
    end
    if (d !== '0) begin
      bad++;
      $display("FAIL mid_d got=%h want=0", d);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_ready got=%b want=1", in_ready);
    end
    repeat (5) tick();
    total++;
    if (got_q.size() != 0 || spurious != sp0) begin
      bad++;
      $display("FAIL mid_stale got=%0d/%0d want=0/%0d",
               got_q.size(), spurious, sp0);
    end
    got_q.delete();
    want_q.delete();
  endtask

`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (cnt_total !== 32'd0 || cnt_apx !== 32'd0) begin
      bad++;
      $display("FAIL cnt_rst got=%0d/%0d want=0/0", cnt_total, cnt_apx);
    end
    out_ready = 1'b1;
    send(DW'($urandom), DW'($urandom), 5'd8, 1'b0);
    send(DW'($urandom), DW'($urandom), 5'd0, 1'b1);
    send(DW'($urandom), DW'($urandom), 5'd8, 1'b0);
    send(DW'($urandom), DW'($urandom), 5'd8, 1'b1);
    send(DW'($urandom), DW'($urandom), 5'd8, 1'b0);
    drain();
    total += 2;
    if (cnt_total !== 32'd5) begin
      bad++;
      $display("FAIL cnt_total got=%0d want=5", cnt_total);
    end
    if (cnt_apx !== 32'd3) begin
      bad++;
      $display("FAIL cnt_apx got=%0d want=3", cnt_apx);
    end
    got_q.delete();
    want_q.delete();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    prec = '0;
    acc__sel = 1'b0;
    out_ready = 1'b1;
    done = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
`ifdef CONF_INT_MUL_PIPE_PERF_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conf_int_mul_pipe.md
Name: conf_int_mul_pipe

Overview:
- Pipelined, runtime-configurable-precision unsigned integer multiplier. Successor to the combinational no-flop configurable multiplier.
- Per transaction, keeps only the top `prec` MSBs of each operand (approximate mode) or computes the full product (accurate mode).
- Valid/ready handshake on input and output, with full-pipeline stall.
- Sits between the PE operand fetch and the accumulator; replaces the wrapper's external accurate/approximate product mux.

Parameters:
- DATA_PATH_BITWIDTH, 32, operand width; product is 2*DATA_PATH_BITWIDTH.
- OP_BITWIDTH, 32, maximum honoured precision; prec values above it are clamped to OP_BITWIDTH. Must satisfy OP_BITWIDTH <= DATA_PATH_BITWIDTH.
- PIPE_STAGES, 2, number of register stages from input accept to out_valid; range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  DATA_PATH_BITWIDTH  operand A, unsigned
- b  in  DATA_PATH_BITWIDTH  operand B, unsigned
- prec  in  PREC_W  kept MSBs per operand; PREC_W = clog2(DATA_PATH_BITWIDTH)+1
- acc__sel  in  1  1 = accurate product, prec ignored
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- d  out  2*DATA_PATH_BITWIDTH  product
- d_apx_flag  out  1  1 if the product was computed with truncated operands

Interface (already decided): single clock `clk`; `rst` is synchronous, active-high.

Behaviour:
- Reset: on `rst` high at a clk edge, all stage valid bits clear, out_valid=0, d=0, d_apx_flag=0, counters=0. Reset mid-operation discards in-flight beats with no output. in_ready=1 in the first cycle after reset.
- Accept: a beat is accepted when in_valid && in_ready.
- Captured per beat: a, b, prec and acc__sel, all latched together. Changing prec does not affect beats already in flight.
- Effective precision: p = acc__sel ? DATA_PATH_BITWIDTH : min(prec, OP_BITWIDTH).
- Operand masking: mask = low (DATA_PATH_BITWIDTH - p) bits cleared; applied to both a and b. p=0 gives product 0. p=DATA_PATH_BITWIDTH gives the exact product.
- d_apx_flag = (p < DATA_PATH_BITWIDTH).
- Arithmetic: d = (a & mask) * (b & mask), full 2*DATA_PATH_BITWIDTH width, no rounding, no saturation.
- Masking happens in stage 1. Multiply is registered, with partial products split across stages when PIPE_STAGES > 1.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1, assuming no stall. Throughput is 1 beat/cycle.
- Stall: the pipeline advances iff (!out_valid || out_ready).
  - in_ready = advance, i.e. a global enable.
  - When stalled, every stage holds, and d and d_apx_flag stay stable while out_valid=1.
- Simultaneous accept and output handshake in the same cycle: both complete; no bubble inserted.
- Bubbles (in_valid=0 while advancing) propagate as invalid stages. d holds its last value when out_valid=0.
- No combinational path from in_valid to in_ready. in_ready depends only on out_valid and out_ready.

Optional Feature:
- Macro: CONF_INT_MUL_PIPE_PERF_CNT_EN.
- Defined: adds two 32-bit output ports, cnt_total and cnt_apx.
  - Each increments on every output handshake (out_valid && out_ready).
  - cnt_apx increments only when d_apx_flag=1.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package conf_mul_pkg holds:
  - function prec_w(width), returning clog2(width)+1;
  - function prec_mask(width, p), returning the operand mask;
  - localparam CNT_W=32.
- Sub-module conf_int_mul_trunc: combinational clamp, mask and flag generation from (a, b, prec, acc__sel). Instantiated once, feeding stage 1.

Test Plan (DATA_PATH_BITWIDTH=16, OP_BITWIDTH=16, PIPE_STAGES=2):
- Exact: a=0x1234, b=0x0100, acc__sel=1, out_ready=1 -> d=0x00123400, d_apx_flag=0, out_valid 2 cycles after accept.
- Truncated: same operands, acc__sel=0, prec=8 -> d=0x00120000, d_apx_flag=1.
- Boundaries, a=0xFFFF, b=0xFFFF, acc__sel=0:
  - prec=0 -> d=0;
  - prec=16 -> d=0xFFFE0001, flag=0;
  - prec=31 -> clamped, d=0xFFFE0001.
- Stall: stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops; d/out_valid stable; all 4 products emerge in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, d=0 next cycle, no stale product ever emitted.
- With CONF_INT_MUL_PIPE_PERF_CNT_EN: 5 beats, 3 with prec=8 and 2 with acc__sel=1 -> cnt_total=5, cnt_apx=3.
